// File: rtl/lo_gen_pkg.sv
// Shared types for the multi-channel LO generator: per-channel config record,
// its reset value and the period helper.
package lo_gen_pkg;

    // Widest divider/dead-time fields a channel supports; top-level fields are zero-extended.
    localparam int LO_DIV_W   = 8;
    localparam int LO_DEAD_W  = 3;
    localparam int LO_DEF_DIV = 3;
    localparam int LO_CNT_W   = LO_DIV_W + 1;

    typedef struct packed {
        logic                en;
        logic [LO_DIV_W-1:0] div;
        logic [LO_DIV_W:0]   phase;
        logic [LO_DEAD_W-1:0] dead;
    } lo_cfg_t;

    localparam lo_cfg_t LO_CFG_RST = '{
        en:    1'b0,
        div:   LO_DIV_W'(LO_DEF_DIV),
        phase: '0,
        dead:  '0
    };

    // Full LO period in clk cycles: two half-periods of (div+1).
    function automatic logic [LO_CNT_W:0] period(input logic [LO_DIV_W-1:0] div);
        return {1'b0, div, 1'b0} + (LO_CNT_W+1)'(2);
    endfunction

endpackage

// File: rtl/lo_generator_if.sv
// Configuration bus of lo_generator: write strobe, target channel, channel
// fields and the global phase-align strobe.
interface lo_generator_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int DEAD_W = 3
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic              cfg_en;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W:0]    cfg_phase;
    logic [DEAD_W-1:0] cfg_dead;
    logic              cfg_sync;

    modport master (
        output cfg_wr, cfg_ch, cfg_en, cfg_div, cfg_phase, cfg_dead, cfg_sync
    );

    modport slave (
        input cfg_wr, cfg_ch, cfg_en, cfg_div, cfg_phase, cfg_dead, cfg_sync
    );

endinterface

// File: rtl/lo_generator_channel.sv
// One LO channel: shadow/active config, period counter and registered
// non-overlapping lo_p/lo_n pair, with an optional external-pair override.
module lo_channel
    import lo_gen_pkg::*;
#(
    parameter int DEF_DIV = LO_DEF_DIV
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wr,
    input  lo_cfg_t wcfg,
    input  logic    sync,
    input  logic    byp,
    input  logic    byp_p,
    input  logic    byp_n,
    output logic    lo_p,
    output logic    lo_n,
    output logic    lo_tick
);

    localparam lo_cfg_t CFG_RST = '{
        en:    LO_CFG_RST.en,
        div:   LO_DIV_W'(DEF_DIV),
        phase: LO_CFG_RST.phase,
        dead:  LO_CFG_RST.dead
    };
    localparam logic [LO_CNT_W-1:0] CNT_ONE  = LO_CNT_W'(1);
    localparam logic [LO_CNT_W:0]   WRAP_ONE = (LO_CNT_W+1)'(1);

    lo_cfg_t             shd, act, shd_eff;
    logic [LO_CNT_W-1:0] cnt, sync_cnt;
    logic [LO_CNT_W:0]   last_act, last_new;
    logic [LO_DIV_W-1:0] dead_x, dead_eff;
    logic [LO_CNT_W-1:0] p_lo, p_hi, n_lo, n_hi;
    logic                wrap, p_nxt, n_nxt, t_nxt;

    // A write in this cycle is already visible to a same-cycle wrap or sync.
    assign shd_eff = wr ? wcfg : shd;

    always_comb begin
        last_act = period(act.div) - WRAP_ONE;
        last_new = period(shd_eff.div) - WRAP_ONE;
        wrap     = ({1'b0, cnt} == last_act);
        sync_cnt = ({1'b0, shd_eff.phase} > last_new) ? last_new[LO_CNT_W-1:0]
                                                       : shd_eff.phase;

        // Dead time is clamped to div so each phase keeps at least one high cycle.
        dead_x   = LO_DIV_W'(act.dead);
        dead_eff = (dead_x > act.div) ? act.div : dead_x;
        p_lo     = {1'b0, dead_eff};
        p_hi     = {1'b0, act.div};
        n_lo     = p_hi + p_lo + CNT_ONE;
        n_hi     = {act.div, 1'b1};

        p_nxt = act.en & (cnt >= p_lo) & (cnt <= p_hi);
        n_nxt = act.en & (cnt >= n_lo) & (cnt <= n_hi);
        t_nxt = act.en & (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shd     <= CFG_RST;
            act     <= CFG_RST;
            cnt     <= '0;
            lo_p    <= 1'b0;
            lo_n    <= 1'b0;
            lo_tick <= 1'b0;
        end else begin
            if (wr)
                shd <= wcfg;

            // A disabled channel tracks its shadow every cycle so enabling starts at cnt=0.
            if (sync) begin
                act <= shd_eff;
                cnt <= shd_eff.en ? sync_cnt : '0;
            end else if (!act.en || wrap) begin
                act <= shd_eff;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end

            if (byp) begin
                lo_p    <= act.en & byp_p;
                lo_n    <= act.en & byp_n;
                lo_tick <= 1'b0;
            end else begin
                lo_p    <= p_nxt;
                lo_n    <= n_nxt;
                lo_tick <= t_nxt;
            end
        end
    end

endmodule

// File: rtl/lo_generator.sv
// NUM_CH-channel LO generator: config write decode, sync fan-out and the
// optional external-LO bypass (enabled with LO_EXT_BYPASS_EN).
module lo_generator
    import lo_gen_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 8,
    parameter int DEAD_W  = 3,
    parameter int DEF_DIV = 3
) (
    input  logic               clk,
    input  logic               rst,
    lo_generator_if.slave      cfg,
    input  logic               ext_lo_en,
    input  logic               ext_lo_p,
    input  logic               ext_lo_n,
    output logic [NUM_CH-1:0]  lo_p,
    output logic [NUM_CH-1:0]  lo_n,
    output logic [NUM_CH-1:0]  lo_tick
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    lo_cfg_t wcfg;
    logic    byp, byp_p, byp_n;

    assign wcfg = '{
        en:    cfg.cfg_en,
        div:   LO_DIV_W'(cfg.cfg_div),
        phase: LO_CNT_W'(cfg.cfg_phase),
        dead:  LO_DEAD_W'(cfg.cfg_dead)
    };

`ifdef LO_EXT_BYPASS_EN
    logic [1:0] sy_p, sy_n;

    // Two-flop synchroniser for the asynchronous external pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            sy_p <= '0;
            sy_n <= '0;
        end else begin
            sy_p <= {sy_p[0], ext_lo_p};
            sy_n <= {sy_n[0], ext_lo_n};
        end
    end

    assign byp   = ext_lo_en;
    assign byp_p = sy_p[1];
    assign byp_n = sy_n[1];
`else
    wire unused_ext = ^{ext_lo_en, ext_lo_p, ext_lo_n};

    assign byp   = 1'b0;
    assign byp_p = 1'b0;
    assign byp_n = 1'b0;
`endif

    // Channel indices beyond NUM_CH-1 match no instance, so such writes drop.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        lo_channel #(
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr      (cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i))),
            .wcfg    (wcfg),
            .sync    (cfg.cfg_sync),
            .byp     (byp),
            .byp_p   (byp_p),
            .byp_n   (byp_n),
            .lo_p    (lo_p[i]),
            .lo_n    (lo_n[i]),
            .lo_tick (lo_tick[i])
        );
    end

endmodule

// File: tb/tb_lo_generator.sv
// Scoreboard bench for lo_generator: a cycle model pushes the expected output
// vector each time stimulus is applied; it is popped and compared after the edge.
module tb_lo_generator;

    localparam int NC = 3, DW = 8, EW = 3, DDIV = 3, CW = 2;
`ifdef LO_EXT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic ext_lo_en = 1'b0, ext_lo_p = 1'b0, ext_lo_n = 1'b0;
    logic [NC-1:0] lo_p, lo_n, lo_tick;

    lo_generator_if #(.NUM_CH(NC), .DIV_W(DW), .DEAD_W(EW)) cfg_if ();

    lo_generator #(.NUM_CH(NC), .DIV_W(DW), .DEAD_W(EW), .DEF_DIV(DDIV)) dut (
        .clk(clk), .rst(rst), .cfg(cfg_if),
        .ext_lo_en(ext_lo_en), .ext_lo_p(ext_lo_p), .ext_lo_n(ext_lo_n),
        .lo_p(lo_p), .lo_n(lo_n), .lo_tick(lo_tick)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: shadow (s_*), active (a_*), counter, synchroniser.
    int s_en[NC], s_div[NC], s_ph[NC], s_dd[NC];
    int a_en[NC], a_div[NC], a_ph[NC], a_dd[NC], m_cnt[NC];
    int sy1p = 0, sy2p = 0, sy1n = 0, sy2n = 0;
    logic [3*NC-1:0] exp_q[$];

    task automatic model_push();
        logic [NC-1:0] ep, eq, et;
        ep = '0; eq = '0; et = '0;
        for (int c = 0; c < NC; c++) begin
            int de;
            de = (a_dd[c] < a_div[c]) ? a_dd[c] : a_div[c];
            if (!rst && a_en[c] != 0) begin
                if (BYP && ext_lo_en) begin
                    ep[c] = (sy2p != 0);
                    eq[c] = (sy2n != 0);
                end else begin
                    ep[c] = (m_cnt[c] >= de) && (m_cnt[c] <= a_div[c]);
                    eq[c] = (m_cnt[c] >= a_div[c] + 1 + de) && (m_cnt[c] <= 2 * a_div[c] + 1);
                    et[c] = (m_cnt[c] == 0);
                end
            end
        end
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                s_en[c] = 0; s_div[c] = DDIV; s_ph[c] = 0; s_dd[c] = 0;
                a_en[c] = 0; a_div[c] = DDIV; a_ph[c] = 0; a_dd[c] = 0;
                m_cnt[c] = 0;
            end
            sy1p = 0; sy2p = 0; sy1n = 0; sy2n = 0;
        end else begin
            for (int c = 0; c < NC; c++)
                if (cfg_if.cfg_wr && cfg_if.cfg_ch == c) begin
                    s_en[c] = cfg_if.cfg_en; s_div[c] = cfg_if.cfg_div;
                    s_ph[c] = cfg_if.cfg_phase; s_dd[c] = cfg_if.cfg_dead;
                end
            for (int c = 0; c < NC; c++) begin
                int last, lim;
                last = 2 * a_div[c] + 1;
                lim  = 2 * s_div[c] + 1;
                if (cfg_if.cfg_sync || a_en[c] == 0 || m_cnt[c] == last) begin
                    a_en[c] = s_en[c]; a_div[c] = s_div[c]; a_ph[c] = s_ph[c]; a_dd[c] = s_dd[c];
                    if (cfg_if.cfg_sync && s_en[c] != 0)
                        m_cnt[c] = (s_ph[c] < lim) ? s_ph[c] : lim;
                    else
                        m_cnt[c] = 0;
                end else begin
                    m_cnt[c]++;
                end
            end
            sy2p = sy1p; sy1p = ext_lo_p;
            sy2n = sy1n; sy1n = ext_lo_n;
        end
        exp_q.push_back({ep, eq, et});
    endtask

    // Window tallies gathered from the DUT outputs for directed checks.
    int t_p0, t_n0, t_k0, t_p1, t_ovl, t_lag5, t_lag1;
    logic prev_p0 = 1'b0;

    task automatic clr();
        t_p0 = 0; t_n0 = 0; t_k0 = 0; t_p1 = 0; t_ovl = 0; t_lag5 = 0; t_lag1 = 0;
    endtask

    task automatic step();
        logic [3*NC-1:0] e;
        model_push();
        @(negedge clk);
        e = exp_q.pop_front();
        chk("outputs", 32'({lo_p, lo_n, lo_tick}), 32'(e));
        t_p0   += int'(lo_p[0]);
        t_n0   += int'(lo_n[0]);
        t_k0   += int'(lo_tick[0]);
        t_p1   += int'(lo_p[1]);
        t_ovl  += int'(|(lo_p & lo_n));
        t_lag5 += int'(lo_p[1] != lo_n[0]);
        t_lag1 += int'(lo_p[1] != prev_p0);
        prev_p0 = lo_p[0];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int ch, input bit en, input int div, input int ph,
                      input int dd, input bit sync);
        cfg_if.cfg_wr    = 1'b1;
        cfg_if.cfg_ch    = CW'(ch);
        cfg_if.cfg_en    = en;
        cfg_if.cfg_div   = DW'(div);
        cfg_if.cfg_phase = (DW+1)'(ph);
        cfg_if.cfg_dead  = EW'(dd);
        cfg_if.cfg_sync  = sync;
        step();
        cfg_if.cfg_wr   = 1'b0;
        cfg_if.cfg_sync = 1'b0;
    endtask

    initial begin
        int k;
        cfg_if.cfg_wr = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_en = 1'b0;
        cfg_if.cfg_div = '0; cfg_if.cfg_phase = '0; cfg_if.cfg_dead = '0;
        cfg_if.cfg_sync = 1'b0;
        clr();

        rst = 1'b1;
        run(3);
        chk("reset_outputs", 32'({lo_p, lo_n, lo_tick}), 32'd0);
        rst = 1'b0;

        // div=3, no dead time: 4 high / 4 high, period 8
        wr(0, 1, 3, 0, 0, 0); run(4); clr(); run(16);
        chk("d3_p_high", t_p0, 8); chk("d3_n_high", t_n0, 8);
        chk("d3_ticks", t_k0, 2);  chk("d3_overlap", t_ovl, 0);

        wr(0, 1, 3, 0, 1, 0); run(10); clr(); run(16);
        chk("dead1_p_high", t_p0, 6); chk("dead1_n_high", t_n0, 6);
        chk("dead1_overlap", t_ovl, 0);

        wr(0, 1, 3, 0, 7, 0); run(10); clr(); run(16);
        chk("dead7_p_high", t_p0, 2); chk("dead7_n_high", t_n0, 2);

        // Phase-aligned restart: ch1 five cycles behind ch0 at period 10
        wr(0, 1, 4, 0, 0, 0); wr(1, 1, 4, 5, 0, 0); wr(0, 1, 4, 0, 0, 1);
        run(3); clr(); run(20);
        chk("ph5_lag", t_lag5, 0); chk("ph5_ch1_high", t_p1, 10);

        // phase 20 clamps to 9: ch1 one cycle behind ch0
        wr(1, 1, 4, 20, 0, 1); run(3); clr(); run(20);
        chk("ph20_clamp", t_lag1, 0); chk("ph20_ch1_high", t_p1, 10);

        // Mid-period divider change, then same-cycle write+sync
        wr(0, 1, 3, 0, 0, 1); run(5); wr(0, 1, 1, 0, 0, 0); run(10); clr(); run(16);
        chk("div1_p_high", t_p0, 8); chk("div1_ticks", t_k0, 4);
        wr(0, 1, 2, 0, 0, 1); run(2); clr(); run(12);
        chk("wrsync_p_high", t_p0, 6); chk("wrsync_ticks", t_k0, 2);

        // External LO: ch0 enabled at div=1, ch1 disabled
        wr(1, 0, 4, 0, 0, 1); wr(0, 1, 1, 0, 0, 0); run(8);
        ext_lo_en = 1'b1;
        for (int i = 0; i < 28; i++) begin
            if (i == 4) clr();
            ext_lo_p = ((i % 6) < 3);
            ext_lo_n = ~ext_lo_p;
            step();
        end
        ext_lo_en = 1'b0; ext_lo_p = 1'b0; ext_lo_n = 1'b0;
        chk("ext_p_high", t_p0, 12); chk("ext_ch1_off", t_p1, 0);
`ifdef LO_EXT_BYPASS_EN
        chk("ext_ticks", t_k0, 0);
`else
        chk("ext_ticks", t_k0, 6);
`endif

        // Random writes (incl. out-of-range channel 3), syncs and bypass toggles
        for (int i = 0; i < 300; i++) begin
            cfg_if.cfg_wr    = ($urandom_range(0, 2) == 0);
            cfg_if.cfg_ch    = CW'($urandom_range(0, 3));
            cfg_if.cfg_en    = ($urandom_range(0, 3) != 0);
            cfg_if.cfg_div   = DW'($urandom_range(0, 6));
            cfg_if.cfg_phase = (DW+1)'($urandom_range(0, 20));
            cfg_if.cfg_dead  = EW'($urandom_range(0, 7));
            cfg_if.cfg_sync  = ($urandom_range(0, 9) == 0);
            ext_lo_en = (i >= 150 && i < 200);
            ext_lo_p  = 1'($urandom_range(0, 1));
            ext_lo_n  = 1'($urandom_range(0, 1));
            step();
        end
        cfg_if.cfg_wr = 1'b0; cfg_if.cfg_sync = 1'b0;
        ext_lo_en = 1'b0; ext_lo_p = 1'b0; ext_lo_n = 1'b0;

        // Reset during a lo_p high phase, colliding with a write and a sync
        wr(0, 1, 3, 0, 0, 1);
        k = 0;
        while (!lo_p[0] && k < 20) begin
            step();
            k++;
        end
        chk("wait_p0_high", 32'(lo_p[0]), 32'd1);
        rst = 1'b1;
        cfg_if.cfg_wr = 1'b1; cfg_if.cfg_ch = '0; cfg_if.cfg_en = 1'b1;
        cfg_if.cfg_div = DW'(5); cfg_if.cfg_sync = 1'b1;
        step();
        chk("rst_mid_outputs", 32'({lo_p, lo_n, lo_tick}), 32'd0);
        rst = 1'b0; cfg_if.cfg_wr = 1'b0; cfg_if.cfg_sync = 1'b0;
        clr(); run(10);
        chk("rst_ch0_off", t_p0, 0); chk("rst_ch0_ticks", t_k0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lo_generator.md
# lo_generator

Parametrised multi-channel local-oscillator generator; successor to `mixer_control`. It produces NUM_CH independent non-overlapping differential LO pairs from `clk`, each with its own programmable divider, phase offset, dead time and enable. An optional external-LO bypass is available. Its outputs drive the `lo_p`/`lo_n` gates of one or more `gilbert_mixer` instances.

## Interface
Parameters:
- NUM_CH, 2, number of LO channels (1..8)
- DIV_W, 8, width of divider and phase fields
- DEAD_W, 3, width of dead-time field
- DEF_DIV, 3, divider value loaded into every channel at reset

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_wr  in  1  one-cycle config write strobe
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel of write
- cfg_en  in  1  channel enable
- cfg_div  in  DIV_W  half-period minus one
- cfg_phase  in  DIV_W+1  start offset in clk cycles
- cfg_dead  in  DEAD_W  non-overlap cycles per half-period
- cfg_sync  in  1  one-cycle strobe: restart all channels phase-aligned
- ext_lo_en  in  1  select external LO for all channels
- ext_lo_p, ext_lo_n  in  1 each  asynchronous external LO pair
- lo_p, lo_n  out  NUM_CH each  registered LO pairs
- lo_tick  out  NUM_CH  one-cycle pulse when channel counter is 0

## Operation
- Per channel: active config {en, div, phase, dead}, shadow config, counter `cnt` in 0..P-1, where P = 2*(div+1).
- Internal mode: lo_p = en & (dead_eff ≤ cnt ≤ div); lo_n = en & (div+1+dead_eff ≤ cnt ≤ 2*div+1). dead_eff = min(dead, div), so each phase is high at least 1 cycle. lo_p and lo_n are never high together.
- Counter: increments each cycle and wraps P-1→0. A disabled channel holds cnt=0 with outputs low.
- cfg_wr writes the shadow of channel cfg_ch. An out-of-range cfg_ch is ignored.
- Shadow→active copy happens at that channel's wrap (cnt==P-1, glitch-free); the counter restarts at 0. Phase is not applied at wrap.
- cfg_sync copies every shadow to active immediately and loads cnt = min(phase, P_new-1) for every channel.
- Enabling a disabled channel takes effect at the next cycle boundary, starting at cnt=0, unless cfg_sync is used.
- cfg_wr and cfg_sync in the same cycle: the write lands in the shadow first; the sync applies the new value.
- Writes to the same channel in consecutive cycles: last write wins.

## Timing
- Reset (rst=1 at edge):
  - cnt=0, en=0 (shadow and active), div=DEF_DIV, phase=0, dead=0.
  - lo_p=lo_n=lo_tick=0, synchroniser flops 0.
- Reset wins over cfg_wr and cfg_sync in the same cycle. Reset mid-period forces outputs low on the next edge.
- Outputs are registered: an output reflects cnt with 1-cycle latency.
- cfg_sync at edge k: new counts are active after edge k; outputs reflect them after edge k+1.
- cfg_wr with wrap: a write at the cycle where cnt==P-1 is applied at that same wrap.
- lo_tick asserts in the output cycle where the lo_p-phase begins (cnt==0), registered like lo_p.

## Configuration
- Macro LO_EXT_BYPASS_EN.
- Defined:
  - ext_lo_p/ext_lo_n pass through a 2-flop synchroniser.
  - When ext_lo_en=1, every enabled channel outputs the synchronised pair, 3-cycle latency from pin. Disabled channels stay low.
  - Internal counters keep running, so switching back is seamless.
  - lo_tick is 0 in bypass.
- Undefined: ext_lo_* ports remain for pin compatibility but are ignored, and no synchroniser flops are built.

## Structure
- Package lo_gen_pkg:
  - struct lo_cfg_t {en, div, phase, dead}
  - DEF_DIV-based reset constant LO_CFG_RST
  - helper function period(div)
- Sub-module lo_channel, instantiated NUM_CH times by generate. It holds shadow/active config, counter and output regs. The top level holds write decode, sync fan-out and the bypass mux.

## Test plan
- Reset, then enable ch0 with div=3, dead=0, no sync → lo_p high 4 cycles, lo_n high 4 cycles, period 8; lo_tick every 8 cycles.
- ch0 div=3, dead=1 → lo_p high 3, lo_n high 3, two 1-cycle both-low gaps. dead=7 clamps to 3 → 1-cycle highs.
- ch0 and ch1 div=4, phase 0 and 5, then cfg_sync → ch1 lags ch0 by exactly 5 cycles (180°). phase=20 clamps to 9.
- Change div 3→1 mid-period via cfg_wr → old period completes, then period 4 starts at cnt=0 with no runt pulse. Same cycle cfg_wr+cfg_sync → new div applied immediately.
- rst asserted mid-high of lo_p → all outputs 0 next edge, div back to DEF_DIV, en=0.
- With LO_EXT_BYPASS_EN, ext_lo_en=1, toggle ext_lo_p → enabled channels follow after 3 clk, disabled stay 0. Without the macro → outputs unaffected.
